// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter in the pixel clock domain: scanout reads,
// CPU plot writes and a background phosphor-fade read-modify-write sweep.
module fb_port_arbiter #(
    parameter int C_addr_bits = 21,
    parameter int C_data_bits = 8,
    parameter int C_pixels    = 1310720
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   scan_req,
    input  logic [C_addr_bits-1:0] scan_addr,
    output logic                   scan_valid,
    output logic [C_data_bits-1:0] scan_data,
    input  logic                   plot_req,
    input  logic [C_addr_bits-1:0] plot_addr,
    input  logic [C_data_bits-1:0] plot_data,
    output logic                   plot_ack,
    input  logic                   fade_start,
    input  logic [C_data_bits-1:0] fade_step,
    output logic                   fade_busy,
    output logic [C_addr_bits-1:0] mem_addr,
    output logic                   mem_we,
    output logic [C_data_bits-1:0] mem_wdata,
    input  logic [C_data_bits-1:0] mem_rdata
);

    localparam int SCAN_LAT = 2;
    localparam logic [C_addr_bits-1:0] LAST_ADDR = C_addr_bits'(C_pixels - 1);

    typedef enum logic [2:0] {
        F_IDLE,
        F_READ,
        F_WAIT1,
        F_WAIT2,
        F_WRITE
    } fade_state_t;

    fade_state_t            fade_state_reg;
    fade_state_t            fade_state_next;
    logic [C_addr_bits-1:0] fade_addr_reg;
    logic [C_data_bits-1:0] fade_step_reg;
    logic [C_data_bits-1:0] fade_val_reg;
    logic [C_data_bits-1:0] fade_wdata;

    logic fade_rd_req;
    logic fade_wr_req;
    logic fade_rmw_open;
    logic plot_hazard;
    logic plot_eligible;
    logic grant_scan;
    logic grant_fade_wr;
    logic grant_plot;
    logic grant_fade_rd;

    logic [C_addr_bits-1:0] mem_addr_reg;
    logic                   mem_we_reg;
    logic [C_data_bits-1:0] mem_wdata_reg;
    logic [C_addr_bits-1:0] slot_addr;
    logic                   slot_we;
    logic [C_data_bits-1:0] slot_wdata;
    logic                   slot_used;

    logic [SCAN_LAT-1:0] scan_pipe_reg;

    // Fade FSM: state register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            fade_state_reg <= F_IDLE;
        end else begin
            fade_state_reg <= fade_state_next;
        end
    end

    // Fade FSM: next-state logic
    always_comb begin
        fade_state_next = fade_state_reg;
        case (fade_state_reg)
            F_IDLE:  if (fade_start) fade_state_next = F_READ;
            F_READ:  if (grant_fade_rd) fade_state_next = F_WAIT1;
            F_WAIT1: fade_state_next = F_WAIT2;
            F_WAIT2: fade_state_next = F_WRITE;
            F_WRITE: begin
                if (grant_fade_wr) begin
                    fade_state_next = (fade_addr_reg == LAST_ADDR) ? F_IDLE : F_READ;
                end
            end
            default: fade_state_next = F_IDLE;
        endcase
    end

    // Fade FSM: outputs
    always_comb begin
        fade_busy     = (fade_state_reg != F_IDLE);
        fade_rd_req   = (fade_state_reg == F_READ);
        fade_wr_req   = (fade_state_reg == F_WRITE);
        fade_rmw_open = (fade_state_reg == F_WAIT1) || (fade_state_reg == F_WAIT2) ||
                        (fade_state_reg == F_WRITE);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            fade_addr_reg <= '0;
            fade_step_reg <= '0;
            fade_val_reg  <= '0;
        end else begin
            case (fade_state_reg)
                F_IDLE: begin
                    if (fade_start) begin
                        fade_step_reg <= fade_step;
                        fade_addr_reg <= '0;
                    end
                end
                F_WAIT2: fade_val_reg <= mem_rdata;
                F_WRITE: begin
                    if (grant_fade_wr && fade_addr_reg != LAST_ADDR) begin
                        fade_addr_reg <= fade_addr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fade_wdata = (fade_val_reg < fade_step_reg) ? '0 : (fade_val_reg - fade_step_reg);

    // A plot to the pixel whose decay is in flight must land after the write-back.
    assign plot_hazard   = fade_rmw_open && (plot_addr == fade_addr_reg);
    assign plot_eligible = plot_req && !plot_hazard;

    assign grant_scan    = scan_req;
    assign grant_fade_wr = fade_wr_req && !scan_req;
    assign grant_plot    = plot_eligible && !scan_req && !fade_wr_req;
    assign grant_fade_rd = fade_rd_req && !scan_req && !fade_wr_req && !plot_eligible;

    assign plot_ack = grant_plot && !reset;

    always_comb begin
        slot_used  = 1'b1;
        slot_we    = 1'b0;
        slot_addr  = mem_addr_reg;
        slot_wdata = mem_wdata_reg;
        if (grant_scan) begin
            slot_addr = scan_addr;
        end else if (grant_fade_wr) begin
            slot_we    = 1'b1;
            slot_addr  = fade_addr_reg;
            slot_wdata = fade_wdata;
        end else if (grant_plot) begin
            slot_we    = 1'b1;
            slot_addr  = plot_addr;
            slot_wdata = plot_data;
        end else if (grant_fade_rd) begin
            slot_addr = fade_addr_reg;
        end else begin
            slot_used = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
        end else begin
            mem_we_reg <= slot_we;
            if (slot_used) begin
                mem_addr_reg  <= slot_addr;
                mem_wdata_reg <= slot_wdata;
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;

    // Scan request follows its read through the RAM latency.
    generate
        for (genvar gi = 0; gi < SCAN_LAT; gi++) begin : g_scan_pipe
            always_ff @(posedge clk_pixel) begin
                if (reset) begin
                    scan_pipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    scan_pipe_reg[gi] <= scan_req;
                end else begin
                    scan_pipe_reg[gi] <= scan_pipe_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign scan_valid = scan_pipe_reg[SCAN_LAT-1];
    assign scan_data  = mem_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: vector table for single-slot arbitration,
// hand sequences for fade passes, the RMW hazard, scan starvation and reset.
module tb_fb_port_arbiter;

    localparam int AW = 21;
    localparam int DW = 8;

    logic          clk_pixel = 1'b0;
    logic          reset;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          plot_req;
    logic [AW-1:0] plot_addr;
    logic [DW-1:0] plot_data;
    logic          plot_ack;
    logic          fade_start;
    logic [DW-1:0] fade_step;
    logic          fade_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          poke_we;
    logic [7:0]    poke_addr;
    logic [7:0]    poke_data;
    logic [7:0]    ram [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_pixel = ~clk_pixel;

    fb_port_arbiter #(
        .C_addr_bits(AW),
        .C_data_bits(DW),
        .C_pixels   (4)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .scan_req  (scan_req),
        .scan_addr (scan_addr),
        .scan_valid(scan_valid),
        .scan_data (scan_data),
        .plot_req  (plot_req),
        .plot_addr (plot_addr),
        .plot_data (plot_data),
        .plot_ack  (plot_ack),
        .fade_start(fade_start),
        .fade_step (fade_step),
        .fade_busy (fade_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port RAM model, read data one cycle after the address is seen.
    always @(posedge clk_pixel) begin
        if (poke_we) ram[poke_addr] <= poke_data;
        else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    typedef struct {
        logic          scan;
        logic [AW-1:0] saddr;
        logic          plot;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pdata;
        logic          exp_ack;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [DW-1:0] exp_sdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_pixel);
        poke_we = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk_pixel);
        poke_we = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_scan_valid"}, scan_valid, 0);
        chk({tag, "_plot_ack"}, plot_ack, 0);
        chk({tag, "_fade_busy"}, fade_busy, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_n;
        int ack_cnt;
        int we_cnt;
        int bad;
        int n;
        logic ack_seen;

        reset = 1'b1;
        scan_req = 1'b0; scan_addr = '0;
        plot_req = 1'b0; plot_addr = '0; plot_data = '0;
        fade_start = 1'b0; fade_step = '0;
        poke_we = 1'b0; poke_addr = '0; poke_data = '0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
        poke(8'h00, 8'h10); poke(8'h01, 8'h03); poke(8'h02, 8'h00); poke(8'h03, 8'h80);
        poke(8'h10, 8'h5A); poke(8'h30, 8'h77);
        @(negedge clk_pixel);
        chk_reset_outputs("reset_init");
        $display("reset: outputs checked");
        reset = 1'b0;

        // scan, saddr, plot, paddr, pdata, ack, we, addr, wdata, sdata
        vecs[0] = '{1'b1, 21'h10, 1'b0, 21'h0,  8'h00, 1'b0, 1'b0, 21'h10, 8'h00, 8'h5A};
        vecs[1] = '{1'b0, 21'h0,  1'b1, 21'h21, 8'h33, 1'b1, 1'b1, 21'h21, 8'h33, 8'h00};
        vecs[2] = '{1'b0, 21'h0,  1'b0, 21'h0,  8'h00, 1'b0, 1'b0, 21'h21, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 21'h30, 1'b1, 21'h40, 8'hEE, 1'b0, 1'b0, 21'h30, 8'h00, 8'h77};
        vecs[4] = '{1'b1, 21'h21, 1'b0, 21'h0,  8'h00, 1'b0, 1'b0, 21'h21, 8'h00, 8'h33};
        vecs[5] = '{1'b0, 21'h0,  1'b1, 21'h05, 8'h00, 1'b1, 1'b1, 21'h05, 8'h00, 8'h00};

        for (int v = 0; v < 6; v++) begin
            @(negedge clk_pixel);
            scan_req = vecs[v].scan; scan_addr = vecs[v].saddr;
            plot_req = vecs[v].plot; plot_addr = vecs[v].paddr; plot_data = vecs[v].pdata;
            #1;
            chk($sformatf("vec%0d_ack", v), plot_ack, vecs[v].exp_ack);
            @(negedge clk_pixel);
            chk($sformatf("vec%0d_we", v), mem_we, vecs[v].exp_we);
            chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].exp_addr);
            if (vecs[v].exp_we) chk($sformatf("vec%0d_wdata", v), mem_wdata, vecs[v].exp_wdata);
            chk($sformatf("vec%0d_valid_early", v), scan_valid, 0);
            scan_req = 1'b0; plot_req = 1'b0;
            @(negedge clk_pixel);
            chk($sformatf("vec%0d_valid", v), scan_valid, vecs[v].scan);
            if (vecs[v].scan) chk($sformatf("vec%0d_sdata", v), scan_data, vecs[v].exp_sdata);
            $display("vec %0d: scan=%0d plot=%0d ack=%0d mem_addr=0x%0h", v, vecs[v].scan,
                     vecs[v].plot, vecs[v].exp_ack, vecs[v].exp_addr);
        end

        // Scan and plot together: scan first, plot acked the cycle after.
        @(negedge clk_pixel);
        scan_req = 1'b1; scan_addr = 21'h10;
        plot_req = 1'b1; plot_addr = 21'h20; plot_data = 8'hFF;
        #1 chk("scanplot_ack0", plot_ack, 0);
        @(negedge clk_pixel);
        chk("scanplot_scan_addr", mem_addr, 21'h10);
        chk("scanplot_scan_we", mem_we, 0);
        scan_req = 1'b0;
        #1 chk("scanplot_ack1", plot_ack, 1);
        @(negedge clk_pixel);
        plot_req = 1'b0;
        chk("scanplot_plot_we", mem_we, 1);
        chk("scanplot_plot_addr", mem_addr, 21'h20);
        chk("scanplot_plot_wdata", mem_wdata, 8'hFF);
        @(negedge clk_pixel);
        chk("scanplot_ram", ram[8'h20], 8'hFF);
        $display("scan-vs-plot: sequence done");

        // Full fade pass over 4 pixels, step 5, with an ignored restart mid-pass.
        @(negedge clk_pixel);
        fade_start = 1'b1; fade_step = 8'h05;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk_pixel);
            n = c;
            if (c == 1) begin
                fade_start = 1'b0;
                chk("fade_busy_rise", fade_busy, 1);
            end
            if (c == 5) begin fade_start = 1'b1; fade_step = 8'h7F; end
            if (c == 6) fade_start = 1'b0;
            if (!fade_busy) break;
        end
        chk("fade_busy_fall_cycle", n, 17);
        chk("fade_last_we", mem_we, 1);
        chk("fade_last_addr", mem_addr, 3);
        chk("fade_last_wdata", mem_wdata, 8'h7B);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        chk("fade_ram0", ram[0], 8'h0B);
        chk("fade_ram1", ram[1], 8'h00);
        chk("fade_ram2", ram[2], 8'h00);
        chk("fade_ram3", ram[3], 8'h7B);
        $display("fade pass: busy fell at cycle %0d", n);

        // Plot to the pixel in mid read-modify-write waits for the write-back.
        poke(8'h02, 8'h40);
        @(negedge clk_pixel);
        fade_start = 1'b1; fade_step = 8'h01;
        ack_n = 0; ack_seen = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_pixel);
            n = c;
            if (c == 1) fade_start = 1'b0;
            if (ack_seen) plot_req = 1'b0;
            if (c == 10) begin plot_req = 1'b1; plot_addr = 21'h02; plot_data = 8'hFF; end
            if (c == 13) begin
                chk("hazard_wb_we", mem_we, 1);
                chk("hazard_wb_addr", mem_addr, 2);
                chk("hazard_wb_wdata", mem_wdata, 8'h3F);
            end
            if (c == 14) begin
                chk("hazard_plot_we", mem_we, 1);
                chk("hazard_plot_wdata", mem_wdata, 8'hFF);
            end
            #1;
            if (plot_ack && ack_n == 0) begin ack_n = c; ack_seen = 1'b1; end
            if (!fade_busy) break;
        end
        plot_req = 1'b0;
        chk("hazard_busy_done", fade_busy, 0);
        chk("hazard_ack_cycle", ack_n, 13);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        chk("hazard_ram2", ram[2], 8'hFF);
        chk("hazard_ram3", ram[3], 8'h7A);
        $display("rmw hazard: plot acked at cycle %0d", ack_n);

        // Back-to-back scan for 100 cycles starves plot and fade (step 0 pass).
        @(negedge clk_pixel);
        scan_req = 1'b1; scan_addr = 21'h10;
        plot_req = 1'b1; plot_addr = 21'h50; plot_data = 8'h99;
        fade_start = 1'b1; fade_step = 8'h00;
        ack_cnt = 0; we_cnt = 0; bad = 0;
        for (int c = 1; c <= 99; c++) begin
            @(negedge clk_pixel);
            if (c == 1) fade_start = 1'b0;
            #1;
            if (plot_ack) ack_cnt++;
            if (mem_we) we_cnt++;
            if (c >= 2 && !(scan_valid && scan_data == 8'h5A)) bad++;
        end
        chk("starve_no_ack", ack_cnt, 0);
        chk("starve_no_write", we_cnt, 0);
        chk("starve_scan_stream", bad, 0);
        chk("starve_fade_busy", fade_busy, 1);
        @(negedge clk_pixel);
        scan_req = 1'b0;
        #1 chk("starve_gap_ack", plot_ack, 1);
        @(negedge clk_pixel);
        plot_req = 1'b0;
        for (int c = 0; c < 100 && fade_busy; c++) @(negedge clk_pixel);
        chk("starve_fade_done", fade_busy, 0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        chk("starve_plot_ram", ram[8'h50], 8'h99);
        chk("starve_step0_ram0", ram[0], 8'h0A);
        chk("starve_step0_ram2", ram[2], 8'hFF);
        $display("scan starvation: plot acked in first gap");

        // Reset while pixel 1 is in its second wait cycle.
        poke(8'h01, 8'h60);
        @(negedge clk_pixel);
        fade_start = 1'b1; fade_step = 8'h10;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_pixel);
            if (c == 1) fade_start = 1'b0;
        end
        chk("rst_pre_addr", mem_addr, 1);
        chk("rst_pre_we", mem_we, 0);
        reset = 1'b1;
        @(negedge clk_pixel);
        chk_reset_outputs("rst_mid");
        reset = 1'b0;
        we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_pixel);
            if (mem_we) we_cnt++;
        end
        chk("rst_no_writeback", we_cnt, 0);
        chk("rst_ram0", ram[0], 8'h00);
        chk("rst_ram1", ram[1], 8'h60);
        @(negedge clk_pixel);
        fade_start = 1'b1; fade_step = 8'h01;
        @(negedge clk_pixel);
        fade_start = 1'b0;
        for (int c = 0; c < 40 && !mem_we; c++) @(negedge clk_pixel);
        chk("restart_first_we", mem_we, 1);
        chk("restart_first_addr", mem_addr, 0);
        chk("restart_first_wdata", mem_wdata, 8'h00);
        for (int c = 0; c < 100 && fade_busy; c++) @(negedge clk_pixel);
        chk("restart_done", fade_busy, 0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        chk("restart_ram1", ram[1], 8'h5F);
        chk("restart_ram3", ram[3], 8'h79);
        $display("reset mid-rmw: restart from address 0 checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port framebuffer RAM in the `clk_pixel` domain between three clients:
  - video scanout reads, which are hard real-time;
  - CPU point-plot writes, already synchronised into `clk_pixel` upstream;
  - an internal phosphor-fade engine that sweeps the buffer doing read-modify-write decay.
- Sits between the PDP-1 display logic, the VGA timing/scanout path feeding `vga2dvid`, and the framebuffer BRAM.

Parameters:
- `C_addr_bits`, 21, framebuffer address width (1280x1024 = 1310720 pixels).
- `C_data_bits`, 8, intensity bits per pixel.
- `C_pixels`, 1310720, number of addresses swept by one fade pass (0 .. `C_pixels`-1).

Ports:
- `clk_pixel`  in  1  pixel clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `scan_req`  in  1  scanout read request, single-cycle pulse.
- `scan_addr`  in  `C_addr_bits`  scanout read address.
- `scan_valid`  out  1  `scan_data` valid.
- `scan_data`  out  `C_data_bits`  scanout read data.
- `plot_req`  in  1  plot write request; held until acked.
- `plot_addr`  in  `C_addr_bits`  plot address.
- `plot_data`  in  `C_data_bits`  plot intensity.
- `plot_ack`  out  1  one-cycle pulse when the plot write is issued.
- `fade_start`  in  1  pulse; begins one full fade pass.
- `fade_step`  in  `C_data_bits`  decrement per pass, sampled at `fade_start`.
- `fade_busy`  out  1  high while a pass is in progress.
- `mem_addr`  out  `C_addr_bits`  RAM address, registered.
- `mem_we`  out  1  RAM write enable, registered.
- `mem_wdata`  out  `C_data_bits`  RAM write data, registered.
- `mem_rdata`  in  `C_data_bits`  RAM read data; valid 1 cycle after `mem_addr`/`mem_we`=0 are seen.

Behaviour:
- **Slot model.** One RAM access per cycle. The winner in cycle N is registered onto `mem_*` at the end of N. The RAM sees it in N+1 and returns read data in N+2.
- **Priority, highest first:**
  1. scan read;
  2. fade write-back;
  3. plot write;
  4. fade read.
- Idle slot: `mem_we`=0, `mem_addr` holds its previous value.
- **Scan path.**
  - `scan_req` is always granted in its cycle; no back-pressure.
  - `scan_valid` = `scan_req` delayed 2 cycles. `scan_data` = `mem_rdata`, passthrough, meaningful only while `scan_valid`=1.
  - Back-to-back `scan_req` every cycle is legal and starves all other clients. The scanout side guarantees gaps during blanking.
- **Plot path.**
  - `plot_ack` pulses in the cycle plot wins arbitration. Caller drops or advances `plot_req` the next cycle.
  - Plot write: `mem_we`=1, `mem_addr`=`plot_addr`, `mem_wdata`=`plot_data`.
- **Fade FSM states:** F_IDLE, F_READ, F_WAIT1, F_WAIT2, F_WRITE.
  - F_IDLE: on `fade_start`, latch `fade_step`, set `fade_addr`=0, go F_READ. `fade_busy`=0 only in F_IDLE.
  - F_READ: request a read of `fade_addr` (priority 4). On grant, go F_WAIT1.
  - F_WAIT1 -> F_WAIT2 unconditionally.
  - F_WAIT2: capture `mem_rdata` into `fade_val`, go F_WRITE.
  - F_WRITE: request a write (priority 2) of `sat(fade_val - step)` to `fade_addr`.
    - Saturating: result is 0 if `fade_val` < step. Step=0 rewrites the value unchanged.
    - On grant: if `fade_addr` = `C_pixels`-1, go F_IDLE; else `fade_addr`+1, go F_READ.
- **Hazard rule.**
  - While the fade FSM is in F_WAIT1, F_WAIT2 or F_WRITE and `plot_addr` == `fade_addr`, plot is not eligible. This prevents the fade write-back from overwriting a fresh plot.
  - The plot is served after the write-back completes, so the plotted value wins.
- **Fade boundaries.**
  - `fade_start` while `fade_busy`=1 is ignored; the step is not re-latched.
  - `fade_addr` wraps from `C_pixels`-1 only by returning to F_IDLE. It never indexes past `C_pixels`-1.
- **Reset:**
  - `scan_valid`=0, `plot_ack`=0, `fade_busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Fade FSM goes to F_IDLE, the scan delay pipe is cleared, and any pass in progress is abandoned.
  - Reset mid-RMW must never issue the pending write-back.

Test Plan:
1. **Scan latency.** Single `scan_req`, `addr`=0x00010, RAM preloaded 0x5A -> `mem_addr`=0x00010 with `we`=0 one cycle later; `scan_valid`=1 with `scan_data`=0x5A exactly 2 cycles after `req`.
2. **Scan beats plot.** `scan_req` and `plot_req` (`addr` 0x00020, `data` 0xFF) together -> scan issued first; `plot_ack` in the next cycle; RAM[0x20]=0xFF.
3. **Fade pass.** `C_pixels`=4 override, RAM={0x10,0x03,0x00,0x80}, `fade_start` with step=0x05 -> RAM={0x0B,0x00,0x00,0x7B}; `fade_busy` falls after the 4th write-back; a second `fade_start` mid-pass changes nothing.
4. **RMW hazard.** Fade reads addr 2 (value 0x40, step 1); `plot_req` to addr 2 with 0xFF during F_WAIT1 -> `plot_ack` withheld until after write-back 0x3F; final RAM[2]=0xFF.
5. **Scan starvation.** Continuous `scan_req` for 100 cycles with `plot_req` pending -> no `plot_ack` and fade frozen; `plot_ack` in the first gap cycle.
6. **Reset mid-operation.** `reset` asserted in F_WAIT2 -> no write issued; all outputs at reset values next cycle; `fade_busy`=0; a new `fade_start` restarts at addr 0.
